// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder
//   Multi-cycle add/subtract unit. A WIDTH-bit operation is processed CHUNK
//   bits per clock through a CHUNK-bit ripple slice. The carry between chunks
//   is held in a register.
//   Subtraction is performed as a + ~b + ~cin.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   operands valid
//   in_ready   unit can accept operands (IDLE only)
//   a, b       operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   sum        result modulo 2^WIDTH
//   cout       final carry (sub mode: 1 = no borrow)
//   overflow   two's-complement overflow
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | adding one chunk per cycle
// DONE  | result presented, waiting for out_ready
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;   // already inverted when subtracting

    logic [CHUNK-1:0] a_sel;
    logic [CHUNK-1:0] b_sel;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic             c_msb;   // carry into the top bit of the slice
    logic             c_rip;
    logic             last;

    assign in_ready = (state == IDLE);
    assign last     = (cnt == CW'(NCHUNK - 1));

    // Chunk select and CHUNK-bit ripple slice.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt == CW'(k)) begin
                a_sel = a_r[k*CHUNK +: CHUNK];
                b_sel = b_r[k*CHUNK +: CHUNK];
            end
        end
        slice_sum = '0;
        c_msb     = 1'b0;
        c_rip     = carry;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) c_msb = c_rip;
            slice_sum[i] = a_sel[i] ^ b_sel[i] ^ c_rip;
            c_rip        = (a_sel[i] & b_sel[i]) | (c_rip & (a_sel[i] ^ b_sel[i]));
        end
        slice_cout = c_rip;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b ^ {WIDTH{sub}};
                        carry <= cin ^ sub;
                        sum   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NCHUNK; k++) begin
                        if (cnt == CW'(k)) sum[k*CHUNK +: CHUNK] <= slice_sum;
                    end
                    carry <= slice_cout;
                    if (last) begin
                        cout      <= slice_cout;
                        overflow  <= slice_cout ^ c_msb;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
